// File: rtl/led_mode_ctrl.sv
// Three-LED pattern controller: key pulses select mode, speed and pause; a prescaler
// with an optional slow sub-divider paces the RUN rotation and BLINK toggling.
module led_mode_ctrl #(
  parameter int unsigned TICK_DIV = 25000000,
  parameter int unsigned SLOW_MUL = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] key_p,
  output logic [2:0] led,
  output logic [1:0] mode,
  output logic       slow,
  output logic       paused
);

  typedef enum logic [1:0] {
    StOff    = 2'd0,
    StStatic = 2'd1,
    StRun    = 2'd2,
    StBlink  = 2'd3
  } mode_e;

  localparam logic [24:0] TickLast = 25'(TICK_DIV - 1);
  localparam logic [1:0]  SubLast  = 2'(SLOW_MUL - 1);

  mode_e       mode_q, mode_d;
  logic [2:0]  led_q, led_d;
  logic        slow_q, slow_d;
  logic        paused_q, paused_d;
  logic [24:0] cnt_q, cnt_d;
  logic [1:0]  sub_q, sub_d;

  logic running;
  logic fast_tick;
  logic step;

  function automatic mode_e next_mode(input mode_e m);
    unique case (m)
      StOff:    next_mode = StStatic;
      StStatic: next_mode = StRun;
      StRun:    next_mode = StBlink;
      StBlink:  next_mode = StOff;
      default:  next_mode = StOff;
    endcase
  endfunction

  function automatic logic [2:0] init_led(input mode_e m);
    unique case (m)
      StOff:    init_led = 3'b000;
      StStatic: init_led = 3'b111;
      StRun:    init_led = 3'b001;
      StBlink:  init_led = 3'b111;
      default:  init_led = 3'b000;
    endcase
  endfunction

  // Pattern timing only advances in the animated modes while not paused.
  always_comb begin
    running   = ((mode_q == StRun) || (mode_q == StBlink)) && !paused_q;
    fast_tick = running && (cnt_q == TickLast);
    step      = fast_tick && (!slow_q || (sub_q == SubLast));
  end

  always_comb begin
    mode_d   = mode_q;
    led_d    = led_q;
    slow_d   = slow_q;
    paused_d = paused_q;
    cnt_d    = cnt_q;
    sub_d    = sub_q;

    if (running) begin
      cnt_d = fast_tick ? 25'd0 : cnt_q + 25'd1;
      if (fast_tick) begin
        sub_d = (sub_q == SubLast) ? 2'd0 : sub_q + 2'd1;
      end
    end

    if (step) begin
      unique case (mode_q)
        StRun:   led_d = {led_q[1:0], led_q[2]};
        StBlink: led_d = ~led_q;
        default: led_d = led_q;
      endcase
    end

    if (key_p[1]) begin
      slow_d = ~slow_q;
      sub_d  = 2'd0;
    end

    // A mode change overrides any step and pause request in the same cycle.
    if (key_p[0]) begin
      mode_d   = next_mode(mode_q);
      led_d    = init_led(mode_d);
      paused_d = 1'b0;
      cnt_d    = 25'd0;
      sub_d    = 2'd0;
    end else if (key_p[2] && ((mode_q == StRun) || (mode_q == StBlink))) begin
      paused_d = ~paused_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q   <= StOff;
      led_q    <= 3'b000;
      slow_q   <= 1'b0;
      paused_q <= 1'b0;
      cnt_q    <= 25'd0;
      sub_q    <= 2'd0;
    end else begin
      mode_q   <= mode_d;
      led_q    <= led_d;
      slow_q   <= slow_d;
      paused_q <= paused_d;
      cnt_q    <= cnt_d;
      sub_q    <= sub_d;
    end
  end

  assign led    = led_q;
  assign mode   = mode_q;
  assign slow   = slow_q;
  assign paused = paused_q;

endmodule

// File: tb/tb_led_mode_ctrl.sv
// Scoreboard bench for led_mode_ctrl: stimulus queues expected outputs tagged with the
// clock edge they belong to; a monitor compares them just after that edge.
module tb_led_mode_ctrl;

  localparam int unsigned TickDiv = 4;
  localparam int unsigned SlowMul = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] key_p = 3'b000;
  logic [2:0] led;
  logic [1:0] mode;
  logic       slow;
  logic       paused;

  led_mode_ctrl #(
    .TICK_DIV(TickDiv),
    .SLOW_MUL(SlowMul)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .key_p (key_p),
    .led   (led),
    .mode  (mode),
    .slow  (slow),
    .paused(paused)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [6:0] exp;
    string      name;
  } exp_t;

  exp_t sb_q[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  task automatic compare(input logic [6:0] exp, input string name);
    logic [6:0] act;
    act = {led, mode, slow, paused};
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got led=%b mode=%0d slow=%b paused=%b, want led=%b mode=%0d slow=%b paused=%b",
               name, cyc, act[6:4], act[3:2], act[1], act[0], exp[6:4], exp[3:2], exp[1], exp[0]);
    end
  endtask

  // Expect outputs (l, m, s, p) after the d-th rising edge from the current negedge.
  task automatic chk(input int d, input logic [2:0] l, input logic [1:0] m, input logic s,
                     input logic p, input string name);
    exp_t e;
    e.cyc  = cyc + d;
    e.exp  = {l, m, s, p};
    e.name = name;
    sb_q.push_back(e);
  endtask

  task automatic step_in(input logic [2:0] k);
    key_p = k;
    @(negedge clk);
    key_p = 3'b000;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  always @(posedge clk) begin
    exp_t e;
    cyc = cyc + 1;
    #1;
    while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
      e = sb_q.pop_front();
      if (e.cyc < cyc) begin
        n_chk++;
        n_fail++;
        $display("FAIL %s: check for cyc %0d missed, now %0d", e.name, e.cyc, cyc);
      end else begin
        compare(e.exp, e.name);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: run did not complete, %0d checks pending", sb_q.size());
    $fatal(1, "timeout");
  end

  logic [2:0] seq_led [4];
  exp_t       left;

  initial begin
    seq_led[0] = 3'b111;
    seq_led[1] = 3'b001;
    seq_led[2] = 3'b111;
    seq_led[3] = 3'b000;

    #2;
    compare(7'b0, "reset_state");
    idle(2);
    rst_n = 1'b1;
    chk(1, 3'b000, 2'd0, 1'b0, 1'b0, "after_reset");
    idle(1);

    // Mode cycle with pulses spaced two cycles apart
    for (int i = 0; i < 4; i++) begin
      chk(1, seq_led[i], 2'((i + 1) % 4), 1'b0, 1'b0, "mode_cycle");
      chk(2, seq_led[i], 2'((i + 1) % 4), 1'b0, 1'b0, "mode_cycle_hold");
      step_in(3'b001);
      idle(1);
    end

    // RUN rotation every 4 cycles; E = entry edge
    chk(1, 3'b111, 2'd1, 1'b0, 1'b0, "to_static");
    step_in(3'b001);
    chk(1, 3'b001, 2'd2, 1'b0, 1'b0, "to_run");
    step_in(3'b001);
    chk(3, 3'b001, 2'd2, 1'b0, 1'b0, "run_e3");
    chk(4, 3'b010, 2'd2, 1'b0, 1'b0, "run_e4");
    chk(7, 3'b010, 2'd2, 1'b0, 1'b0, "run_e7");
    chk(8, 3'b100, 2'd2, 1'b0, 1'b0, "run_e8");
    chk(12, 3'b001, 2'd2, 1'b0, 1'b0, "run_e12");
    idle(12);

    // Speed toggle on a tick edge: that step still applies, next one 16 cycles later
    idle(3);
    chk(1, 3'b010, 2'd2, 1'b1, 1'b0, "slow_on");
    step_in(3'b010);
    chk(15, 3'b010, 2'd2, 1'b1, 1'b0, "slow_hold15");
    chk(16, 3'b100, 2'd2, 1'b1, 1'b0, "slow_step16");
    idle(16);
    chk(1, 3'b100, 2'd2, 1'b0, 1'b0, "slow_off");
    step_in(3'b010);
    chk(2, 3'b100, 2'd2, 1'b0, 1'b0, "fast_hold");
    chk(3, 3'b001, 2'd2, 1'b0, 1'b0, "fast_step");
    chk(7, 3'b010, 2'd2, 1'b0, 1'b0, "fast_step2");
    idle(7);

    // Pause in RUN, then mode+pause together
    chk(1, 3'b010, 2'd2, 1'b0, 1'b1, "run_pause");
    step_in(3'b100);
    chk(5, 3'b010, 2'd2, 1'b0, 1'b1, "run_paused_hold");
    idle(5);
    chk(1, 3'b111, 2'd3, 1'b0, 1'b0, "mode_over_pause");
    step_in(3'b101);

    // BLINK: pause registered at F+2, frozen 20 cycles, resume toggles 2 cycles later
    idle(1);
    chk(1, 3'b111, 2'd3, 1'b0, 1'b1, "blink_pause");
    step_in(3'b100);
    chk(8, 3'b111, 2'd3, 1'b0, 1'b1, "blink_frozen8");
    chk(19, 3'b111, 2'd3, 1'b0, 1'b1, "blink_frozen19");
    idle(19);
    chk(1, 3'b111, 2'd3, 1'b0, 1'b0, "blink_resume");
    step_in(3'b100);
    chk(1, 3'b111, 2'd3, 1'b0, 1'b0, "blink_resume_hold");
    chk(2, 3'b000, 2'd3, 1'b0, 1'b0, "blink_toggle");
    idle(2);

    // Mode key on a step edge: the blink toggle is discarded
    idle(3);
    chk(1, 3'b000, 2'd0, 1'b0, 1'b0, "step_discarded");
    step_in(3'b001);
    chk(4, 3'b000, 2'd0, 1'b0, 1'b0, "off_hold");
    idle(4);

    // Pause ignored in STATIC
    chk(1, 3'b111, 2'd1, 1'b0, 1'b0, "static");
    step_in(3'b001);
    chk(1, 3'b111, 2'd1, 1'b0, 1'b0, "static_no_pause");
    step_in(3'b100);

    // Held mode key counts as one press per cycle
    chk(1, 3'b001, 2'd2, 1'b0, 1'b0, "held_1");
    chk(2, 3'b111, 2'd3, 1'b0, 1'b0, "held_2");
    chk(3, 3'b000, 2'd0, 1'b0, 1'b0, "held_3");
    key_p = 3'b001;
    idle(3);
    key_p = 3'b000;

    // Mode and speed together, then RUN with slow=1 and async reset mid-cycle
    chk(1, 3'b111, 2'd1, 1'b1, 1'b0, "mode_and_speed");
    step_in(3'b011);
    chk(1, 3'b001, 2'd2, 1'b1, 1'b0, "run_slow");
    step_in(3'b001);
    chk(5, 3'b001, 2'd2, 1'b1, 1'b0, "run_slow_hold");
    idle(5);
    #2;
    rst_n = 1'b0;
    #1;
    compare(7'b0, "async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    chk(1, 3'b000, 2'd0, 1'b0, 1'b0, "post_reset");
    idle(1);

    // Fresh RUN after reset; pause landing on a step edge keeps that step
    chk(1, 3'b111, 2'd1, 1'b0, 1'b0, "re_static");
    step_in(3'b001);
    chk(1, 3'b001, 2'd2, 1'b0, 1'b0, "re_run");
    step_in(3'b001);
    chk(3, 3'b001, 2'd2, 1'b0, 1'b0, "re_run_hold");
    idle(3);
    chk(1, 3'b010, 2'd2, 1'b0, 1'b1, "pause_on_step");
    step_in(3'b100);
    chk(8, 3'b010, 2'd2, 1'b0, 1'b1, "pause_on_step_hold");
    idle(8);

    for (int i = 0; i < 20 && sb_q.size() > 0; i++) @(negedge clk);
    while (sb_q.size() > 0) begin
      left = sb_q.pop_front();
      n_chk++;
      n_fail++;
      $display("FAIL %s: expected at cyc %0d, never compared", left.name, left.cyc);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
